// File: rtl/imem_port_arbiter_if.sv
// Bundle of fetch, loader and RAM-command signals around the instruction RAM arbiter.
// slave = arbiter side, master = requesters + RAM side.
interface imem_port_arbiter_if #(
  parameter int DEPTH     = 256,
  parameter int ADDR_LEN  = 32,
  parameter int INSTR_LEN = 32
);
  localparam int IW = $clog2(DEPTH);

  logic                 fetch_req;
  logic [ADDR_LEN-1:0]  fetch_addr;
  logic                 fetch_gnt;
  logic                 fetch_rvalid;
  logic [INSTR_LEN-1:0] fetch_rdata;

  logic                 ld_req;
  logic                 ld_we;
  logic [31:0]          ld_addr;
  logic [31:0]          ld_wdata;
  logic                 ld_lock;
  logic                 ld_gnt;
  logic                 ld_rvalid;
  logic [31:0]          ld_rdata;

  logic                 locked;
  logic                 addr_err;

  logic                 mem_en;
  logic                 mem_we;
  logic [IW-1:0]        mem_addr;
  logic [31:0]          mem_wdata;
  logic [31:0]          mem_rdata;

  modport slave (
    input  fetch_req, fetch_addr, ld_req, ld_we, ld_addr, ld_wdata, ld_lock, mem_rdata,
    output fetch_gnt, fetch_rvalid, fetch_rdata, ld_gnt, ld_rvalid, ld_rdata,
           locked, addr_err, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output fetch_req, fetch_addr, ld_req, ld_we, ld_addr, ld_wdata, ld_lock, mem_rdata,
    input  fetch_gnt, fetch_rvalid, fetch_rdata, ld_gnt, ld_rvalid, ld_rdata,
           locked, addr_err, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_port_arbiter.sv
// Shares a single-port synchronous-read instruction RAM between CPU fetch and the loader,
// with round-robin arbitration, a lock/drain mode for program loading and address checks.
module imem_port_arbiter #(
  parameter int DEPTH      = 256,
  parameter int LOCK_DRAIN = 1
) (
  input logic clk,
  input logic rst,
  imem_port_arbiter_if.slave bus
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = (LOCK_DRAIN < 2) ? 1 : $clog2(LOCK_DRAIN + 1);

  typedef enum logic [1:0] {RUN, DRAIN, LOCK} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   drain_cnt, cnt_nxt;
  logic            rr, rr_nxt;        // 0 = fetch favoured, 1 = loader favoured
  logic [1:0]      req, gnt, legal;   // index 0 = fetch, 1 = loader
  logic [1:0][31:0] addr;
  logic            owner, rd_pending, err_q;
  logic            any_gnt, sel_legal, wr, rd_issue;
  logic [31:0]     ret_data;

  assign req  = {bus.ld_req, bus.fetch_req};
  assign addr = {bus.ld_addr, bus.fetch_addr};

  for (genvar r = 0; r < 2; r++) begin : g_chk
    assign legal[r] = (addr[r][1:0] == 2'b00) && (addr[r][31:IW+2] == '0);
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = drain_cnt;
    rr_nxt    = rr;
    gnt       = '0;
    case (state)
      RUN: begin
        // A contested request is not resolved in the cycle lock rises.
        if (&req) begin
          if (!bus.ld_lock) begin
            gnt[rr] = 1'b1;
            rr_nxt  = ~rr;
          end
        end else begin
          gnt = req;
        end
        if (bus.ld_lock) begin
          state_nxt = DRAIN;
          cnt_nxt   = CW'(LOCK_DRAIN);
        end
      end
      DRAIN: begin
        if (!bus.ld_lock)              state_nxt = RUN;
        else if (drain_cnt <= CW'(1))  state_nxt = LOCK;
        else                           cnt_nxt   = drain_cnt - CW'(1);
      end
      LOCK: begin
        gnt[1] = req[1];
        if (!bus.ld_lock) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
    if (rst) gnt = '0;
  end

  assign any_gnt   = |gnt;
  assign sel_legal = gnt[1] ? legal[1] : legal[0];
  assign wr        = gnt[1] & bus.ld_we;
  // Illegal accesses still return a (zero) response, writes included.
  assign rd_issue  = any_gnt & (~wr | ~sel_legal);

  assign bus.fetch_gnt = gnt[0];
  assign bus.ld_gnt    = gnt[1];
  assign bus.mem_en    = any_gnt & sel_legal;
  assign bus.mem_we    = bus.mem_en & wr;
  assign bus.mem_addr  = !bus.mem_en ? '0 :
                         gnt[1] ? bus.ld_addr[IW+1:2] : bus.fetch_addr[IW+1:2];
  assign bus.mem_wdata = bus.mem_we ? bus.ld_wdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      drain_cnt  <= '0;
      rr         <= 1'b0;
      owner      <= 1'b0;
      rd_pending <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state      <= state_nxt;
      drain_cnt  <= cnt_nxt;
      rr         <= rr_nxt;
      owner      <= gnt[1];
      rd_pending <= rd_issue;
      err_q      <= any_gnt & ~sel_legal;
    end
  end

  assign ret_data         = (rd_pending && !err_q && !rst) ? bus.mem_rdata : '0;
  assign bus.fetch_rvalid = ~rst & rd_pending & ~owner;
  assign bus.ld_rvalid    = ~rst & rd_pending & owner;
  assign bus.fetch_rdata  = owner ? '0 : ret_data;
  assign bus.ld_rdata     = owner ? ret_data : '0;
  assign bus.locked       = ~rst & (state == LOCK);
  assign bus.addr_err     = ~rst & err_q;
endmodule

// File: tb/tb_imem_port_arbiter.sv
// Random + directed bench for imem_port_arbiter: a behavioural model predicts grants and
// RAM commands; a scoreboard queue per requester checks returned data one cycle later.
module tb_imem_port_arbiter;
  localparam int DEPTH      = 256;
  localparam int LOCK_DRAIN = 1;
  localparam int RUN_M = 0, DRAIN_M = 1, LOCK_M = 2;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imem_port_arbiter_if #(.DEPTH(DEPTH)) bus();

  imem_port_arbiter #(.DEPTH(DEPTH), .LOCK_DRAIN(LOCK_DRAIN)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference contents and model state
  logic [31:0] ref_mem [DEPTH];
  int   m_mode = RUN_M;
  int   m_dspent = 0;
  logic m_rr = 1'b0;
  rsp_t fq[$];
  rsp_t lq[$];

  // Pending requests held until granted
  logic        f_pend = 0, l_pend = 0, l_we = 0, lock = 0, rst_v = 1, ram_load = 1;
  logic [31:0] f_addr = 0, l_addr = 0, l_wdata = 0;

  // RAM environment
  logic [31:0] ram [DEPTH];
  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= ref_mem[i];
    end else if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata <= ram[bus.mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 99) < 85) return 32'($urandom_range(0, DEPTH-1)) * 4;
    if ($urandom_range(0, 1) == 1)
      return 32'($urandom_range(0, DEPTH-1)) * 4 + 32'($urandom_range(1, 3));
    return $urandom() | 32'(DEPTH * 4);
  endfunction

  // One clock of stimulus: drive, predict, compare combinational outputs, advance model.
  task automatic cycle();
    logic gf, gl, legal, wr, exp_en, both;
    logic [31:0] a;
    rsp_t e;
    @(negedge clk);
    rst            = rst_v;
    bus.fetch_req  = f_pend;
    bus.fetch_addr = f_addr;
    bus.ld_req     = l_pend;
    bus.ld_we      = l_we;
    bus.ld_addr    = l_addr;
    bus.ld_wdata   = l_wdata;
    bus.ld_lock    = lock;
    #1;
    gf = 0; gl = 0;
    both = f_pend && l_pend;
    if (!rst_v) begin
      if (m_mode == RUN_M) begin
        if (both) begin
          if (!lock) begin gf = (m_rr == 0); gl = (m_rr == 1); end
        end else begin
          gf = f_pend; gl = l_pend;
        end
      end else if (m_mode == LOCK_M) begin
        gl = l_pend;
      end
    end
    a      = gl ? l_addr : f_addr;
    legal  = (a % 4 == 0) && (a < 32'(DEPTH * 4));
    wr     = gl && l_we;
    exp_en = (gf || gl) && legal;
    chk("fetch_gnt", bus.fetch_gnt, gf);
    chk("ld_gnt", bus.ld_gnt, gl);
    chk("locked", bus.locked, !rst_v && m_mode == LOCK_M);
    chk("mem_en", bus.mem_en, exp_en);
    chk("mem_we", bus.mem_we, exp_en && wr);
    chk("mem_addr", bus.mem_addr, exp_en ? a / 4 : 0);
    chk("mem_wdata", bus.mem_wdata, (exp_en && wr) ? l_wdata : 0);
    e.err  = !legal;
    e.data = 0;
    if (legal) e.data = ref_mem[a / 4];
    @(posedge clk);
    if (gf) fq.push_back(e);
    if (gl && (!l_we || !legal)) lq.push_back(e);
    if (exp_en && wr) ref_mem[a / 4] = l_wdata;
    if (gf) f_pend = 0;
    if (gl) l_pend = 0;
    if (rst_v) begin
      m_mode = RUN_M; m_rr = 0; m_dspent = 0;
    end else begin
      case (m_mode)
        RUN_M: begin
          if (both && (gf || gl)) m_rr = gf;  // loser becomes favoured
          if (lock) begin m_mode = DRAIN_M; m_dspent = 0; end
        end
        DRAIN_M: begin
          m_dspent++;
          if (!lock) m_mode = RUN_M;
          else if (m_dspent >= LOCK_DRAIN) m_mode = LOCK_M;
        end
        default: if (!lock) m_mode = RUN_M;
      endcase
    end
  endtask

  // Response monitor
  initial begin
    rsp_t e;
    logic err, ef, el;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        chk("rst_fetch_rvalid", bus.fetch_rvalid, 0);
        chk("rst_ld_rvalid", bus.ld_rvalid, 0);
        chk("rst_fetch_rdata", bus.fetch_rdata, 0);
        chk("rst_ld_rdata", bus.ld_rdata, 0);
        chk("rst_addr_err", bus.addr_err, 0);
        fq.delete();
        lq.delete();
      end else begin
        err = 0;
        ef  = fq.size() > 0;
        el  = lq.size() > 0;
        chk("fetch_rvalid", bus.fetch_rvalid, ef);
        chk("ld_rvalid", bus.ld_rvalid, el);
        if (ef) begin
          e = fq.pop_front(); err |= e.err;
          chk("fetch_rdata", bus.fetch_rdata, e.data);
        end else chk("fetch_rdata_idle", bus.fetch_rdata, 0);
        if (el) begin
          e = lq.pop_front(); err |= e.err;
          chk("ld_rdata", bus.ld_rdata, e.data);
        end else chk("ld_rdata_idle", bus.ld_rdata, 0);
        chk("addr_err", bus.addr_err, err);
      end
    end
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = $urandom();
    ref_mem[3] = 32'h0022_1820;
    bus.mem_rdata = 0;
    rst_v = 1; ram_load = 1;
    repeat (2) cycle();
    rst_v = 0; ram_load = 0;

    // Single fetch of word 3
    f_pend = 1; f_addr = 32'h0000_000C;
    repeat (2) cycle();

    // Contested: expect fetch, ld, fetch, ld
    for (int i = 0; i < 4; i++) begin
      if (!f_pend) begin f_pend = 1; f_addr = 32'h4; end
      if (!l_pend) begin l_pend = 1; l_we = 0; l_addr = 32'h0; end
      cycle();
    end
    f_pend = 0; l_pend = 0;
    cycle();

    // Lock, load 0x3C while fetch waits, release, fetch it back
    lock = 1;
    repeat (2) cycle();
    l_pend = 1; l_we = 1; l_addr = 32'h3C; l_wdata = 32'h1234_5678;
    f_pend = 1; f_addr = 32'h3C;
    repeat (3) cycle();
    lock = 0;
    repeat (3) cycle();

    // Misaligned fetch
    f_pend = 1; f_addr = 32'h6;
    repeat (2) cycle();

    // Out-of-range loader write, then read word 0 back
    l_pend = 1; l_we = 1; l_addr = 32'h400; l_wdata = 32'hDEAD_BEEF;
    cycle();
    l_pend = 1; l_we = 0; l_addr = 32'h0;
    repeat (2) cycle();

    // Reset right after a fetch grant, then a contested request favours fetch
    f_pend = 1; f_addr = 32'h10;
    cycle();
    rst_v = 1;
    cycle();
    rst_v = 0;
    f_pend = 1; f_addr = 32'h14;
    l_pend = 1; l_we = 0; l_addr = 32'h18;
    repeat (3) cycle();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      if (!f_pend && $urandom_range(0, 99) < 60) begin f_pend = 1; f_addr = rand_addr(); end
      if (!l_pend && $urandom_range(0, 99) < 50) begin
        l_pend = 1; l_we = 1'($urandom_range(0, 1)); l_addr = rand_addr(); l_wdata = $urandom();
      end
      if ($urandom_range(0, 99) < 3) lock = !lock;
      rst_v = ($urandom_range(0, 299) == 0);
      cycle();
    end

    rst_v = 0; lock = 0; f_pend = 0; l_pend = 0;
    repeat (4) cycle();
    chk("leftover_responses", 32'(fq.size() + lq.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
